fp_add_arbiter: RTL and testbench
=================================

// Module: fp_add_arbiter
// PURPOSE
//  Shares the single-precision float adder between two requesters: port 0 is the FP execute
//  stage and port 1 is the multi-cycle FP unit. Grants one operation at a time, round-robin.
//  Holds the adder operands stable for LATENCY cycles, captures the sum and returns it over
//  a valid/ready handshake. The adder is external: add_a/add_b drive it, add_res feeds back.
// PARAMETERS
//  LATENCY   2   cycles the adder operands are held before add_res is sampled (>=1)
//  TAG_W     5   width of the requester tag (dest register id) carried through with the op
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req0_valid in   1      requester 0 has an operation
//  req0_ready out  1      requester 0 operation accepted this cycle
//  req0_a     in   32     operand A, IEEE-754 single
//  req0_b     in   32     operand B, IEEE-754 single
//  req0_sub   in   1      1 = A - B, 0 = A + B
//  req0_tag   in   TAG_W  tag returned with the result
//  req1_*     (same set as req0_*, for requester 1)
//  add_a      out  32     to adder input a
//  add_b      out  32     to adder input b (sign of B inverted when sub=1)
//  add_res    in   32     adder result (combinational from add_a/add_b)
//  res_valid  out  1      result available
//  res_ready  in   1      consumer takes the result
//  res_data   out  32     registered result
//  res_id     out  1      requester that owns res_data
//  res_tag    out  TAG_W  tag of that operation
//  busy       out  1      1 in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, prio=0, cnt=0. All operand, result and tag registers are 0, so add_a,
//   add_b, res_data, res_tag, res_id, res_valid and busy are all 0. Reset acts immediately.
//  FSM IDLE -> EXEC -> DONE -> IDLE. Only one operation is in flight. No accept in EXEC/DONE.
//  IDLE:
//   - req0_ready = req0_valid & (prio==0 | ~req1_valid); req1_ready is symmetric.
//   - Both readys are combinational. At most one is high, and only in IDLE.
//   - On an accept: latch a, b^{sub,31'b0}, tag and id. Set cnt=LATENCY-1 and go to EXEC.
//   - On an accept: prio <= ~granted id, so the other requester wins the next tie.
//   - With no request valid, stay in IDLE and leave prio unchanged.
//  EXEC:
//   - add_a and add_b come from the latched registers and stay stable for the whole state.
//   - cnt decrements each cycle. In the cycle with cnt==0: res_data <= add_res and go to DONE.
//   - EXEC therefore lasts exactly LATENCY cycles.
//  DONE:
//   - res_valid=1. res_data, res_id and res_tag are held stable until res_ready=1.
//   - The transfer completes on a cycle with res_valid & res_ready. Go to IDLE on the next cycle.
//  Latency: from the accept edge to res_valid high is LATENCY+1 cycles.
//   Minimum spacing between accepts is LATENCY+2 cycles.
//  Requester rules: a requester holds valid and its fields stable until ready.
//   Dropping valid before ready is legal; the request is then simply not taken.
//  Arithmetic: the block does no FP math itself. Only the sign of B is inverted for sub.
//   NaN, Inf and denormals pass to the adder untouched.
//  Reset mid-op: the operation in flight is discarded and no result is produced.
// TESTING
//  1 LATENCY=2: req0 a=3F800000 b=40000000 sub=0 tag=3 -> req0_ready at T0, res_valid at T3,
//    res_data=40400000, res_id=0, res_tag=3.
//  2 req1 a=40400000 b=3F800000 sub=1 -> add_b=BF800000 during EXEC, res_data=40000000, res_id=1.
//  3 Both requesters valid continuously from reset -> grants in order 0,1,0,1.
//    Each grant comes exactly LATENCY+2 cycles after the previous one.
//  4 Hold res_ready=0 for 5 cycles in DONE -> res_valid stays 1, res_data/tag do not change,
//    req0_ready=req1_ready=0, busy=1. Then res_ready=1 -> IDLE on the next cycle.
//  5 Assert rst_n=0 mid-EXEC -> busy, add_a and res_valid go to 0 immediately (no clock edge).
//    After release, req1 alone is served with the correct result and prio=0.
//  6 LATENCY=1 build: repeat scenario 1 -> res_valid at T2, same data.

Source files
------------

// File: rtl/fp_add_arbiter_if.sv
// rtl/fp_add_arbiter_if.sv - request, adder and result signals of the shared FP adder arbiter
interface fp_add_arbiter_if #(
    parameter int TAG_W = 5
);
    // requester 0 (FP execute stage)
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic             req0_sub;
    logic [TAG_W-1:0] req0_tag;
    // requester 1 (multi-cycle FP unit)
    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic             req1_sub;
    logic [TAG_W-1:0] req1_tag;
    // external adder
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_res;
    // result return
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic             res_id;
    logic [TAG_W-1:0] res_tag;
    logic             busy;

    // the environment: requesters, adder and result consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_sub, req0_tag,
        output req1_valid, req1_a, req1_b, req1_sub, req1_tag,
        output add_res, res_ready,
        input  req0_ready, req1_ready, add_a, add_b,
        input  res_valid, res_data, res_id, res_tag, busy
    );

    // the arbiter
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_sub, req1_tag,
        input  add_res, res_ready,
        output req0_ready, req1_ready, add_a, add_b,
        output res_valid, res_data, res_id, res_tag, busy
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one external FP adder between two requesters
module fp_add_arbiter #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_add_arbiter_if.slave  bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic             prio;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [31:0]      res_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             cnt_zero;

    assign accept   = grant0 | grant1;
    assign cnt_zero = (cnt == '0);

    // next state and grants; grants only exist in IDLE, prio breaks ties
    always_comb begin
        state_d = state;
        grant0  = 1'b0;
        grant1  = 1'b0;
        case (state)
            IDLE: begin
                grant0 = bus.req0_valid & (~prio | ~bus.req1_valid);
                grant1 = bus.req1_valid & (prio | ~bus.req0_valid);
                if (grant0 | grant1) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // operand latch on accept, latency countdown in EXEC, result capture on the last EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio  <= 1'b0;
            cnt   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res_q <= '0;
            tag_q <= '0;
            id_q  <= 1'b0;
        end else if (accept) begin
            op_a  <= grant1 ? bus.req1_a : bus.req0_a;
            op_b  <= grant1 ? (bus.req1_b ^ {bus.req1_sub, 31'b0})
                            : (bus.req0_b ^ {bus.req0_sub, 31'b0});
            tag_q <= grant1 ? bus.req1_tag : bus.req0_tag;
            id_q  <= grant1;
            prio  <= ~grant1;
            cnt   <= CNT_W'(LATENCY - 1);
        end else if (state == EXEC) begin
            if (cnt_zero) begin
                res_q <= bus.add_res;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // operands come straight from the latch so the adder sees them stable through EXEC
    assign bus.add_a      = op_a;
    assign bus.add_b      = op_b;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.res_valid  = (state == DONE);
    assign bus.res_data   = res_q;
    assign bus.res_id     = id_q;
    assign bus.res_tag    = tag_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - directed self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;
    localparam int TAG_W = 5;

    logic clk;
    logic rst_n;
    int   n_err;
    int   n_chk;

    fp_add_arbiter_if #(.TAG_W(TAG_W)) bus2 ();
    fp_add_arbiter_if #(.TAG_W(TAG_W)) bus1 ();

    fp_add_arbiter #(.LATENCY(2), .TAG_W(TAG_W)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    fp_add_arbiter #(.LATENCY(1), .TAG_W(TAG_W)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    // hand-computed single-precision sums for the operand pairs used below
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: fadd = 32'h40400000;
            {32'h40400000, 32'hBF800000}: fadd = 32'h40000000;
            {32'h40000000, 32'h40000000}: fadd = 32'h40800000;
            {32'h3F800000, 32'hBF800000}: fadd = 32'h00000000;
            default:                      fadd = 32'hFFFFFFFF;
        endcase
    endfunction

    assign bus2.add_res = fadd(bus2.add_a, bus2.add_b);
    assign bus1.add_res = fadd(bus1.add_a, bus1.add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] exp_data;
        logic        exp_id;
        logic [4:0]  exp_tag;
        n_err = 0;
        n_chk = 0;
        rst_n = 1'b0;
        bus2.req0_valid = 0; bus2.req0_a = 0; bus2.req0_b = 0; bus2.req0_sub = 0; bus2.req0_tag = 0;
        bus2.req1_valid = 0; bus2.req1_a = 0; bus2.req1_b = 0; bus2.req1_sub = 0; bus2.req1_tag = 0;
        bus2.res_ready  = 1;
        bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_sub = 0; bus1.req0_tag = 0;
        bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_sub = 0; bus1.req1_tag = 0;
        bus1.res_ready  = 1;

        // reset values
        #3;
        chk("rst_busy",      32'(bus2.busy),      0);
        chk("rst_res_valid", 32'(bus2.res_valid), 0);
        chk("rst_add_a",     bus2.add_a,          0);
        chk("rst_add_b",     bus2.add_b,          0);
        chk("rst_res_data",  bus2.res_data,       0);
        chk("rst_res_tag",   32'(bus2.res_tag),   0);
        chk("rst_res_id",    32'(bus2.res_id),    0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // 1: req0 1.0 + 2.0, tag 3
        bus2.req0_valid = 1; bus2.req0_a = 32'h3F800000; bus2.req0_b = 32'h40000000;
        bus2.req0_sub = 0; bus2.req0_tag = 5'd3;
        smp();
        chk("s1_ready0", 32'(bus2.req0_ready), 1);
        chk("s1_ready1", 32'(bus2.req1_ready), 0);
        cyc();
        bus2.req0_valid = 0;
        smp();
        chk("s1_t1_busy",  32'(bus2.busy),       1);
        chk("s1_t1_valid", 32'(bus2.res_valid),  0);
        chk("s1_t1_add_a", bus2.add_a,           32'h3F800000);
        chk("s1_t1_add_b", bus2.add_b,           32'h40000000);
        chk("s1_t1_rdy0",  32'(bus2.req0_ready), 0);
        cyc(); smp();
        chk("s1_t2_valid", 32'(bus2.res_valid), 0);
        cyc(); smp();
        chk("s1_t3_valid", 32'(bus2.res_valid), 1);
        chk("s1_t3_data",  bus2.res_data,       32'h40400000);
        chk("s1_t3_id",    32'(bus2.res_id),    0);
        chk("s1_t3_tag",   32'(bus2.res_tag),   3);
        cyc(); smp();
        chk("s1_t4_busy",  32'(bus2.busy),      0);
        chk("s1_t4_valid", 32'(bus2.res_valid), 0);

        // 2: req1 3.0 - 1.0, tag 7
        cyc();
        bus2.req1_valid = 1; bus2.req1_a = 32'h40400000; bus2.req1_b = 32'h3F800000;
        bus2.req1_sub = 1; bus2.req1_tag = 5'd7;
        smp();
        chk("s2_ready1", 32'(bus2.req1_ready), 1);
        chk("s2_ready0", 32'(bus2.req0_ready), 0);
        cyc();
        bus2.req1_valid = 0;
        smp();
        chk("s2_t1_add_a", bus2.add_a, 32'h40400000);
        chk("s2_t1_add_b", bus2.add_b, 32'hBF800000);
        cyc(); smp();
        chk("s2_t2_add_b", bus2.add_b, 32'hBF800000);
        cyc(); smp();
        chk("s2_t3_valid", 32'(bus2.res_valid), 1);
        chk("s2_t3_data",  bus2.res_data,       32'h40000000);
        chk("s2_t3_id",    32'(bus2.res_id),    1);
        chk("s2_t3_tag",   32'(bus2.res_tag),   7);
        cyc(); smp();
        chk("s2_t4_busy", 32'(bus2.busy), 0);

        // 3: both requesters valid from reset release, grants every 4 cycles alternating 0,1
        cyc();
        rst_n = 1'b0;
        bus2.req0_valid = 1; bus2.req0_a = 32'h40000000; bus2.req0_b = 32'h40000000;
        bus2.req0_sub = 0; bus2.req0_tag = 5'd1;
        bus2.req1_valid = 1; bus2.req1_a = 32'h3F800000; bus2.req1_b = 32'h3F800000;
        bus2.req1_sub = 1; bus2.req1_tag = 5'd2;
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            smp();
            chk($sformatf("s3_k%0d_rdy0", k), 32'(bus2.req0_ready),
                ((k % 4) == 0 && ((k / 4) % 2) == 0) ? 32'd1 : 32'd0);
            chk($sformatf("s3_k%0d_rdy1", k), 32'(bus2.req1_ready),
                ((k % 4) == 0 && ((k / 4) % 2) == 1) ? 32'd1 : 32'd0);
            if ((k % 4) == 3) begin
                exp_id   = ((k / 4) % 2) == 1;
                exp_data = exp_id ? 32'h00000000 : 32'h40800000;
                exp_tag  = exp_id ? 5'd2 : 5'd1;
                chk($sformatf("s3_k%0d_valid", k), 32'(bus2.res_valid), 1);
                chk($sformatf("s3_k%0d_data", k),  bus2.res_data,       exp_data);
                chk($sformatf("s3_k%0d_id", k),    32'(bus2.res_id),    32'(exp_id));
                chk($sformatf("s3_k%0d_tag", k),   32'(bus2.res_tag),   32'(exp_tag));
            end
            cyc();
        end
        bus2.req0_valid = 0;
        bus2.req1_valid = 0;

        // 4: consumer stalls 5 cycles in DONE
        bus2.res_ready  = 0;
        bus2.req0_valid = 1; bus2.req0_a = 32'h40000000; bus2.req0_b = 32'h40000000;
        bus2.req0_sub = 0; bus2.req0_tag = 5'd9;
        smp();
        chk("s4_ready0", 32'(bus2.req0_ready), 1);
        cyc();
        bus2.req0_valid = 0;
        bus2.req1_valid = 1;
        smp();
        cyc(); smp();
        cyc();
        for (int i = 0; i < 5; i++) begin
            smp();
            chk($sformatf("s4_h%0d_valid", i), 32'(bus2.res_valid),  1);
            chk($sformatf("s4_h%0d_data", i),  bus2.res_data,        32'h40800000);
            chk($sformatf("s4_h%0d_tag", i),   32'(bus2.res_tag),    9);
            chk($sformatf("s4_h%0d_busy", i),  32'(bus2.busy),       1);
            chk($sformatf("s4_h%0d_rdy0", i),  32'(bus2.req0_ready), 0);
            chk($sformatf("s4_h%0d_rdy1", i),  32'(bus2.req1_ready), 0);
            cyc();
        end
        bus2.res_ready  = 1;
        bus2.req1_valid = 0;
        smp();
        chk("s4_rel_valid", 32'(bus2.res_valid), 1);
        chk("s4_rel_data",  bus2.res_data,       32'h40800000);
        cyc(); smp();
        chk("s4_idle_busy",  32'(bus2.busy),      0);
        chk("s4_idle_valid", 32'(bus2.res_valid), 0);

        // 5: reset in the middle of EXEC
        cyc();
        bus2.req0_valid = 1; bus2.req0_a = 32'h3F800000; bus2.req0_b = 32'h40000000;
        bus2.req0_sub = 0; bus2.req0_tag = 5'd3;
        smp();
        chk("s5_ready0", 32'(bus2.req0_ready), 1);
        cyc();
        bus2.req0_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_busy",  32'(bus2.busy),      0);
        chk("s5_rst_add_a", bus2.add_a,          0);
        chk("s5_rst_valid", 32'(bus2.res_valid), 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        bus2.req0_valid = 1;
        bus2.req1_valid = 1; bus2.req1_a = 32'h40400000; bus2.req1_b = 32'h3F800000;
        bus2.req1_sub = 1; bus2.req1_tag = 5'd4;
        smp();
        chk("s5_prio_rdy0", 32'(bus2.req0_ready), 1);
        chk("s5_prio_rdy1", 32'(bus2.req1_ready), 0);
        #1;
        bus2.req0_valid = 0;
        #1;
        chk("s5_alone_rdy1", 32'(bus2.req1_ready), 1);
        chk("s5_alone_rdy0", 32'(bus2.req0_ready), 0);
        cyc();
        bus2.req1_valid = 0;
        smp();
        chk("s5_t1_add_b", bus2.add_b, 32'hBF800000);
        cyc(); smp();
        cyc(); smp();
        chk("s5_t3_valid", 32'(bus2.res_valid), 1);
        chk("s5_t3_data",  bus2.res_data,       32'h40000000);
        chk("s5_t3_id",    32'(bus2.res_id),    1);
        chk("s5_t3_tag",   32'(bus2.res_tag),   4);
        cyc(); smp();
        chk("s5_t4_busy", 32'(bus2.busy), 0);

        // 6: LATENCY=1 build, scenario 1 again
        cyc();
        bus1.req0_valid = 1; bus1.req0_a = 32'h3F800000; bus1.req0_b = 32'h40000000;
        bus1.req0_sub = 0; bus1.req0_tag = 5'd3;
        smp();
        chk("s6_ready0", 32'(bus1.req0_ready), 1);
        cyc();
        bus1.req0_valid = 0;
        smp();
        chk("s6_t1_valid", 32'(bus1.res_valid), 0);
        chk("s6_t1_busy",  32'(bus1.busy),      1);
        cyc(); smp();
        chk("s6_t2_valid", 32'(bus1.res_valid), 1);
        chk("s6_t2_data",  bus1.res_data,       32'h40400000);
        chk("s6_t2_id",    32'(bus1.res_id),    0);
        chk("s6_t2_tag",   32'(bus1.res_tag),   3);
        cyc(); smp();
        chk("s6_t3_busy", 32'(bus1.busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
